spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_pkg.sv | 27 ++
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_flash_reader.sv | 103 ++++++++++
 tb/tb_spi_flash_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash READ (0x03) engine.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;
  localparam int         DATA_BITS    = 32;

  // Index of the final bit of each serial phase.
  function automatic logic [5:0] phase_last(input state_t s);
    case (s)
      ST_CMD:  phase_last = 6'(CMD_BITS - 1);
      ST_ADDR: phase_last = 6'(ADDR_BITS - 1);
      ST_DATA: phase_last = 6'(DATA_BITS - 1);
      default: phase_last = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock divider: low half then high half per bit, with rise/fall strobes
// asserted in the clk cycle whose closing edge moves spi_clk.
module spi_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_sclk;
  logic       w_term;

  assign w_term = (r_div == DIV_LAST);
  assign o_rise = i_en && !r_sclk && w_term;
  assign o_fall = i_en &&  r_sclk && w_term;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || i_restart) begin
      r_div  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (w_term) begin
      r_div  <= 8'd0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Single-word SPI flash reader: READ command, 24-bit address, 32 data bits returned
// little-endian, then a minimum chip-select-high gap before the next request.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CSB_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t                 r_state, w_next;
  logic [5:0]             r_bit_cnt;
  logic [3:0]             r_gap_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_data;

  logic w_active, w_rise, w_fall, w_last_bit, w_accept, w_chg, w_done;

  assign w_active   = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign req_ready  = (r_state == ST_IDLE) && (r_gap_cnt == 4'd0);
  assign w_accept   = req_valid && req_ready;
  assign w_last_bit = w_fall && (r_bit_cnt == phase_last(r_state));
  assign w_done     = (r_state == ST_DATA) && w_last_bit;
  assign w_chg      = (w_next != r_state);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (w_active),
    .i_restart (w_chg),
    .o_sclk    (spi_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next = ST_CMD;
      ST_CMD:  if (w_last_bit) w_next = ST_ADDR;
      ST_ADDR: if (w_last_bit) w_next = ST_DATA;
      ST_DATA: if (w_last_bit) w_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt <= 4'd1) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // One shift register serves both directions: command+address drain out of the
  // MSB on falling strobes, then data fills in at the LSB on rising strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= 6'd0;
      r_gap_cnt   <= 4'(CSB_GAP);
      r_shift     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_chg)       r_bit_cnt <= 6'd0;
      else if (w_fall) r_bit_cnt <= r_bit_cnt + 6'd1;

      if (w_done)                  r_gap_cnt <= 4'(CSB_GAP);
      else if (r_gap_cnt != 4'd0)  r_gap_cnt <= r_gap_cnt - 4'd1;

      if (w_accept)
        r_shift <= {SPI_CMD_READ, req_addr & 24'hFF_FFFC};
      else if (w_rise && r_state == ST_DATA)
        r_shift <= {r_shift[DATA_BITS-2:0], spi_miso};
      else if (w_fall && r_state != ST_DATA)
        r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};

      // First byte on the wire lands in the top of the shifter; swap to little-endian.
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= {r_shift[7:0], r_shift[15:8], r_shift[23:16], r_shift[31:24]};
      end
    end
  end

  assign spi_csb   = !w_active;
  assign spi_mosi  = ((r_state == ST_CMD) || (r_state == ST_ADDR)) && r_shift[DATA_BITS-1];
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV 1 and 3) each talking to a
// behavioural flash memory; expectations come from the memory image and timing rules.
module tb_spi_flash_reader;

  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_a;
  logic [1:0]        req_valid_a;
  logic [1:0][23:0]  req_addr_a;
  wire  [1:0]        req_ready_a, rsp_valid_a, csb_a, sclk_a, mosi_a, miso_a;
  wire  [1:0][31:0]  rsp_data_a, obs_a, per_a, bad_a, minrun_a;

  logic [7:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic fbit(input logic [23:0] a, input int i);
    logic [7:0] b;
    b = mem[(int'(a) + i / 8) & 4095];
    return b[7 - (i % 8)];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : 3;

    spi_flash_reader #(.CLK_DIV(D), .CSB_GAP(GAP)) u_dut (
      .clk       (clk),
      .rst       (rst_a[g]),
      .req_valid (req_valid_a[g]),
      .req_ready (req_ready_a[g]),
      .req_addr  (req_addr_a[g]),
      .rsp_valid (rsp_valid_a[g]),
      .rsp_data  (rsp_data_a[g]),
      .spi_csb   (csb_a[g]),
      .spi_clk   (sclk_a[g]),
      .spi_mosi  (mosi_a[g]),
      .spi_miso  (miso_a[g])
    );

    // Flash model: captures command+address on spi_clk rises, shifts data out on falls.
    int          n_rise = 0, since = 0, per = 0, mosi_bad = 0, run = 0, minrun = 1000;
    bit          seen_low = 1'b0;
    logic        csb_q = 1'b1, sclk_q = 1'b0, r_miso = 1'b0;
    logic [31:0] cmd_sh = 32'd0;

    always @(negedge clk) begin
      if (!csb_a[g]) begin
        if (csb_q) begin
          n_rise = 0;
          since  = 0;
          if (seen_low && run > 0 && run < minrun) minrun = run;
          seen_low = 1'b1;
          run      = 0;
        end
        since++;
        if (sclk_a[g] && !sclk_q) begin
          if (n_rise < 32) cmd_sh = {cmd_sh[30:0], mosi_a[g]};
          else if (mosi_a[g]) mosi_bad++;
          if (n_rise > 0) per = since;
          since = 0;
          n_rise++;
        end else if (!sclk_a[g] && sclk_q && n_rise >= 32 && n_rise < 64) begin
          r_miso = fbit(cmd_sh[23:0], n_rise - 32);
        end
      end else begin
        run++;
      end
      csb_q  = csb_a[g];
      sclk_q = sclk_a[g];
    end

    assign miso_a[g]   = r_miso;
    assign obs_a[g]    = cmd_sh;
    assign per_a[g]    = per;
    assign bad_a[g]    = mosi_bad;
    assign minrun_a[g] = minrun;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input int k, input logic [23:0] a, input bit hold);
    int d, t, lat, lowc, rdyc;
    logic [23:0] aa;
    logic [31:0] exp, held;
    d    = (k == 0) ? 1 : 3;
    aa   = a & 24'hFF_FFFC;
    exp  = {mem[(int'(aa) + 3) & 4095], mem[(int'(aa) + 2) & 4095],
            mem[(int'(aa) + 1) & 4095], mem[int'(aa) & 4095]};
    req_addr_a[k]  = a;
    req_valid_a[k] = 1'b1;
    t = 0;
    while (!req_ready_a[k] && t < 2000) begin @(negedge clk); t++; end
    chk("accept_timeout", t < 2000, 1);
    @(negedge clk);
    if (!hold) req_valid_a[k] = 1'b0;
    lat = 1; lowc = 0; rdyc = 0;
    while (!rsp_valid_a[k] && lat < 2000) begin
      if (!csb_a[k]) lowc++;
      if (req_ready_a[k]) rdyc++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, 128 * d + 1);
    chk("rsp_data", rsp_data_a[k], exp);
    chk("csb_low_cycles", lowc, 128 * d);
    chk("ready_during_xfer", rdyc + int'(req_ready_a[k]), 0);
    chk("csb_at_rsp", csb_a[k], 1'b1);
    chk("sclk_at_rsp", sclk_a[k], 1'b0);
    chk("mosi_stream", obs_a[k], {8'h03, aa});
    chk("sclk_period", per_a[k], 2 * d);
    held = rsp_data_a[k];
    @(negedge clk);
    chk("rsp_single_pulse", rsp_valid_a[k], 1'b0);
    chk("rsp_data_hold", rsp_data_a[k], held);
  endtask

  task automatic release_chk(input int k);
    int lowc, csb_lo;
    lowc = 0; csb_lo = 0;
    rst_a[k] = 1'b0;
    while (!req_ready_a[k] && lowc < 50) begin
      if (!csb_a[k]) csb_lo++;
      lowc++;
      @(negedge clk);
    end
    chk("rst_ready_low_cycles", lowc, GAP);
    chk("rst_csb_high", csb_lo, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int rspc, csbl;
    rst_a       = 2'b11;
    req_valid_a = 2'b00;
    req_addr_a  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0]     = 8'hD5; mem[1]     = 8'h00; mem[2]     = 8'h00; mem[3]     = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", req_ready_a[k], 1'b0);
      chk("rst_rsp_valid", rsp_valid_a[k], 1'b0);
      chk("rst_rsp_data", rsp_data_a[k], 32'd0);
      chk("rst_csb", csb_a[k], 1'b1);
      chk("rst_sclk", sclk_a[k], 1'b0);
      chk("rst_mosi", mosi_a[k], 1'b0);
    end
    rst_a[1] = 1'b0;
    release_chk(0);
    chk("rst_ready_inst1", req_ready_a[1], 1'b1);

    do_read(0, 24'h000000, 1'b0);
    do_read(0, 24'h123457, 1'b0);
    do_read(1, 24'h000100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_read(0, 24'($urandom), 1'b0);
      do_read(1, 24'($urandom), 1'b0);
    end

    do_read(0, 24'($urandom), 1'b1);
    do_read(0, 24'($urandom), 1'b0);
    chk("csb_gap_min", minrun_a[0] >= GAP && minrun_a[0] < 1000, 1);

    // Abort a read part-way through the address phase.
    req_addr_a[0]  = 24'h000000;
    req_valid_a[0] = 1'b1;
    begin
      int t;
      t = 0;
      while (!req_ready_a[0] && t < 2000) begin @(negedge clk); t++; end
    end
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_mid_xfer_csb", csb_a[0], 1'b0);
    rst_a[0] = 1'b1;
    @(negedge clk);
    chk("abort_csb", csb_a[0], 1'b1);
    chk("abort_sclk", sclk_a[0], 1'b0);
    chk("abort_rsp_valid", rsp_valid_a[0], 1'b0);
    release_chk(0);
    rspc = 0; csbl = 0;
    repeat (150) begin
      @(negedge clk);
      if (rsp_valid_a[0]) rspc++;
      if (!csb_a[0]) csbl++;
    end
    chk("abort_no_rsp", rspc, 0);
    chk("abort_csb_idle", csbl, 0);
    do_read(0, 24'h000000, 1'b0);

    chk("mosi_low_in_data_0", bad_a[0], 0);
    chk("mosi_low_in_data_1", bad_a[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
